// File: rtl/dice_turn_ctrl.sv
// Turn controller for two-player Pig: drives the roller enable, captures fresh rolls,
// keeps turn and banked totals, handles hold/bust and declares the winner.
module dice_turn_ctrl #(
    parameter int TARGET  = 50,
    parameter int SCORE_W = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         roll_num,
    input  logic               roll_choose,
    input  logic               hold_btn,
    input  logic               new_game,
    output logic               roll_enable,
    output logic               cur_player,
    output logic [SCORE_W-1:0] turn_total,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic [2:0]         last_roll,
    output logic               busted,
    output logic               game_over,
    output logic               winner
);

    typedef enum logic [1:0] {ARM, SPIN, APPLY, WIN} state_t;

    localparam logic [SCORE_W-1:0] TARGET_W = SCORE_W'(TARGET);

    state_t               state_reg, state_next;
    logic                 hold_prev_reg;
    logic                 hold_edge;
    logic                 cur_player_reg, cur_player_next;
    logic [SCORE_W-1:0]   turn_total_reg, turn_total_next;
    logic [2:0]           last_roll_reg, last_roll_next;
    logic                 busted_reg, busted_next;
    logic                 winner_reg, winner_next;
    logic                 bank_en;
    logic                 clear_all;
    logic [SCORE_W-1:0]   bank_val;
    logic [1:0][SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0]   cur_score;
    logic [SCORE_W-1:0]   arm_sum;
    logic [SCORE_W-1:0]   apply_tt;
    logic [SCORE_W-1:0]   apply_sum;

    assign hold_edge = hold_btn & ~hold_prev_reg;
    assign cur_score = score_q[cur_player_reg];
    assign arm_sum   = cur_score + turn_total_reg;
    assign apply_tt  = turn_total_reg + SCORE_W'(last_roll_reg);
    assign apply_sum = cur_score + apply_tt;

    // State and turn bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ARM;
            hold_prev_reg  <= 1'b0;
            cur_player_reg <= 1'b0;
            turn_total_reg <= '0;
            last_roll_reg  <= '0;
            busted_reg     <= 1'b0;
            winner_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hold_prev_reg  <= hold_btn;
            cur_player_reg <= cur_player_next;
            turn_total_reg <= turn_total_next;
            last_roll_reg  <= last_roll_next;
            busted_reg     <= busted_next;
            winner_reg     <= winner_next;
        end
    end

    // One banked-score register per player; only the active player's bank lands
    for (genvar gi = 0; gi < 2; gi++) begin : g_score
        logic [SCORE_W-1:0] score_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                score_reg <= '0;
            end else if (clear_all) begin
                score_reg <= '0;
            end else if (bank_en && (cur_player_reg == 1'(gi))) begin
                score_reg <= bank_val;
            end
        end

        assign score_q[gi] = score_reg;
    end

    // Next-state and datapath updates
    always_comb begin
        state_next      = state_reg;
        cur_player_next = cur_player_reg;
        turn_total_next = turn_total_reg;
        last_roll_next  = last_roll_reg;
        busted_next     = 1'b0;
        winner_next     = winner_reg;
        bank_en         = 1'b0;
        bank_val        = arm_sum;
        clear_all       = 1'b0;

        if (new_game) begin
            state_next      = ARM;
            cur_player_next = 1'b0;
            turn_total_next = '0;
            last_roll_next  = '0;
            winner_next     = 1'b0;
            clear_all       = 1'b1;
        end else begin
            unique case (state_reg)
                ARM: begin
                    // A high roll_choose here is the roller's held value, never a new roll
                    if (hold_edge && (turn_total_reg != '0)) begin
                        bank_en         = 1'b1;
                        bank_val        = arm_sum;
                        turn_total_next = '0;
                        if (arm_sum >= TARGET_W) begin
                            state_next  = WIN;
                            winner_next = cur_player_reg;
                        end else begin
                            cur_player_next = ~cur_player_reg;
                        end
                    end else if (!roll_choose) begin
                        state_next = SPIN;
                    end
                end
                SPIN: begin
                    if (roll_choose) begin
                        last_roll_next = roll_num;
                        state_next     = APPLY;
                    end
                end
                APPLY: begin
                    state_next = ARM;
                    if (last_roll_reg == 3'd1) begin
                        turn_total_next = '0;
                        cur_player_next = ~cur_player_reg;
                        busted_next     = 1'b1;
                    end else if ((last_roll_reg >= 3'd2) && (last_roll_reg <= 3'd6)) begin
                        if (apply_sum >= TARGET_W) begin
                            bank_en         = 1'b1;
                            bank_val        = apply_sum;
                            turn_total_next = '0;
                            winner_next     = cur_player_reg;
                            state_next      = WIN;
                        end else begin
                            turn_total_next = apply_tt;
                        end
                    end
                end
                WIN: begin
                    state_next = WIN;
                end
                default: begin
                    state_next = ARM;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        roll_enable = (state_reg == ARM) || (state_reg == SPIN);
        game_over   = (state_reg == WIN);
        cur_player  = cur_player_reg;
        turn_total  = turn_total_reg;
        score0      = score_q[0];
        score1      = score_q[1];
        last_roll   = last_roll_reg;
        busted      = busted_reg;
        winner      = winner_reg;
    end

endmodule

// File: tb/tb_dice_turn_ctrl.sv
// Directed bench for dice_turn_ctrl: rolls, holds, busts, stale choose, win and reset.
module tb_dice_turn_ctrl;

    localparam int SW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    roll_num;
    logic          roll_choose;
    logic          hold_btn;
    logic          new_game;
    logic          roll_enable;
    logic          cur_player;
    logic [SW-1:0] turn_total;
    logic [SW-1:0] score0;
    logic [SW-1:0] score1;
    logic [2:0]    last_roll;
    logic          busted;
    logic          game_over;
    logic          winner;

    int total = 0;
    int bad   = 0;

    dice_turn_ctrl #(.TARGET(50), .SCORE_W(SW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .roll_num    (roll_num),
        .roll_choose (roll_choose),
        .hold_btn    (hold_btn),
        .new_game    (new_game),
        .roll_enable (roll_enable),
        .cur_player  (cur_player),
        .turn_total  (turn_total),
        .score0      (score0),
        .score1      (score1),
        .last_roll   (last_roll),
        .busted      (busted),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starting from ARM: release choose, present a value, capture it, apply it.
    task automatic do_roll(input logic [2:0] v);
        roll_choose = 1'b0;
        step();
        roll_choose = 1'b1;
        roll_num    = v;
        step();
        step();
        $display("roll %0d: player=%0d turn=%0d s0=%0d s1=%0d", v, cur_player, turn_total, score0, score1);
    endtask

    task automatic do_hold();
        hold_btn = 1'b1;
        step();
        hold_btn = 1'b0;
        $display("hold: player=%0d turn=%0d s0=%0d s1=%0d over=%0d", cur_player, turn_total, score0, score1, game_over);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_en"},   int'(roll_enable), 1);
        check({tag, "_s0"},   int'(score0), 0);
        check({tag, "_s1"},   int'(score1), 0);
        check({tag, "_tt"},   int'(turn_total), 0);
        check({tag, "_cp"},   int'(cur_player), 0);
        check({tag, "_lr"},   int'(last_roll), 0);
        check({tag, "_over"}, int'(game_over), 0);
        check({tag, "_win"},  int'(winner), 0);
        check({tag, "_bust"}, int'(busted), 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        roll_num    = 3'd0;
        roll_choose = 1'b0;
        hold_btn    = 1'b0;
        new_game    = 1'b0;
        #3;
        check_cleared("rst");
        step();
        step();
        rst_n = 1'b1;
        check_cleared("rel");

        // ARM -> SPIN on the first edge, then capture 4
        step();
        roll_choose = 1'b1;
        roll_num    = 3'd4;
        step();
        check("cap4_lr", int'(last_roll), 4);
        check("cap4_tt", int'(turn_total), 0);
        check("cap4_en", int'(roll_enable), 0);
        step();
        check("app4_tt", int'(turn_total), 4);
        check("app4_en", int'(roll_enable), 1);
        do_roll(3'd5);
        check("r5_tt", int'(turn_total), 9);
        do_hold();
        check("hold_s0", int'(score0), 9);
        check("hold_tt", int'(turn_total), 0);
        check("hold_cp", int'(cur_player), 1);

        // Player 1: 3 then bust on 1
        do_roll(3'd3);
        check("p1_r3_tt", int'(turn_total), 3);
        check("p1_r3_bust", int'(busted), 0);
        do_roll(3'd1);
        check("bust_tt", int'(turn_total), 0);
        check("bust_pulse", int'(busted), 1);
        check("bust_cp", int'(cur_player), 0);
        check("bust_s1", int'(score1), 0);
        step();
        check("bust_done", int'(busted), 0);

        // Hold with empty turn total does nothing
        do_hold();
        check("hold0_cp", int'(cur_player), 0);
        check("hold0_s0", int'(score0), 9);

        // Stale choose: one 6 counted once despite choose held high
        do_roll(3'd6);
        for (int i = 0; i < 10; i++) step();
        check("stale_tt", int'(turn_total), 6);

        // Hold edge in SPIN is ignored
        roll_choose = 1'b0;
        step();
        hold_btn = 1'b1;
        step();
        check("spinhold_tt", int'(turn_total), 6);
        check("spinhold_s0", int'(score0), 9);
        check("spinhold_cp", int'(cur_player), 0);
        hold_btn    = 1'b0;
        roll_choose = 1'b1;
        roll_num    = 3'd2;
        step();
        step();
        check("spin_r2_tt", int'(turn_total), 8);

        new_game = 1'b1;
        step();
        new_game = 1'b0;
        check_cleared("ng1");

        // Build score0 = 46, pass the turn back via a bust, then win on a 4
        for (int i = 0; i < 7; i++) do_roll(3'd6);
        do_roll(3'd4);
        check("pre_tt", int'(turn_total), 46);
        do_hold();
        check("pre_s0", int'(score0), 46);
        check("pre_cp", int'(cur_player), 1);
        do_roll(3'd1);
        check("pass_cp", int'(cur_player), 0);
        do_roll(3'd4);
        check("win_s0", int'(score0), 50);
        check("win_tt", int'(turn_total), 0);
        check("win_over", int'(game_over), 1);
        check("win_who", int'(winner), 0);
        check("win_en", int'(roll_enable), 0);

        // Inputs ignored in WIN
        roll_choose = 1'b0;
        step();
        roll_choose = 1'b1;
        roll_num    = 3'd5;
        step();
        do_hold();
        step();
        check("winhold_s0", int'(score0), 50);
        check("winhold_s1", int'(score1), 0);
        check("winhold_over", int'(game_over), 1);
        check("winhold_lr", int'(last_roll), 4);

        new_game = 1'b1;
        step();
        new_game = 1'b0;
        check_cleared("ng2");

        // Asynchronous reset while a 6 sits in APPLY
        roll_choose = 1'b0;
        step();
        roll_choose = 1'b1;
        roll_num    = 3'd6;
        step();
        check("pend_lr", int'(last_roll), 6);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_lr", int'(last_roll), 0);
        check("arst_en", int'(roll_enable), 1);
        check("arst_tt", int'(turn_total), 0);
        roll_choose = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        check("post_tt", int'(turn_total), 0);
        check("post_s0", int'(score0), 0);
        check("post_lr", int'(last_roll), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
